// File: rtl/scl_tick_receiver.sv
// scl_tick_receiver: brings the slow divider clock (clk_scl_in) into the clk domain,
// turns every qualified edge into a one-cycle tick, measures edge spacing in clk
// cycles and flags a stall when edges stop arriving for TIMEOUT cycles.
module scl_tick_receiver #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT     = 100000000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_scl_in,
  input  logic             en,
  output logic             tick,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             stalled,
  output logic [15:0]      edge_cnt
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, STALL} state_t;

  // Last counter value before a missing edge is declared a stall.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   prev_q;
  logic                   raw_edge;
  logic                   q_edge;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       period_d;
  logic                   tick_d, rise_d, fall_d;
  logic                   valid_d, stalled_d;
  logic [15:0]            edge_cnt_d;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign raw_edge = sync_out ^ prev_q;
  // Rising-only mode ignores the falling half of each slow period.
  assign q_edge   = (EDGE_MODE == 1) ? (sync_out & ~prev_q) : raw_edge;

  // Synchroniser chain plus the previous-value flop; prev tracks in every state
  // so that entering ACQUIRE never sees a stale difference as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value,
      // which is what makes this a real shift chain rather than one wire.
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_scl_in};
      prev_q <= sync_out;
    end
  end

  // Next-state, counter and output decode; en low overrides everything.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    tick_d     = 1'b0;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    period_d   = period;
    valid_d    = period_valid;
    stalled_d  = stalled;
    edge_cnt_d = edge_cnt;

    if (!en) begin
      state_d    = IDLE;
      cnt_d      = '0;
      period_d   = '0;
      valid_d    = 1'b0;
      stalled_d  = 1'b0;
      edge_cnt_d = '0;
    end else begin
      if (q_edge && state_q != IDLE) begin
        tick_d     = 1'b1;
        rise_d     = sync_out;
        fall_d     = ~sync_out;
        edge_cnt_d = edge_cnt + 16'd1;
      end
      case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
          cnt_d   = '0;
        end
        ACQUIRE: begin
          if (q_edge) begin
            cnt_d   = '0;
            state_d = TRACK;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = STALL;
            stalled_d = 1'b1;
            valid_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        TRACK: begin
          if (q_edge) begin
            period_d = cnt_q + CNT_W'(1);
            valid_d  = 1'b1;
            cnt_d    = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = STALL;
            stalled_d = 1'b1;
            valid_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STALL: begin
          // Counter stays frozen; the next edge restarts timing, and a valid
          // period only comes back one edge later.
          if (q_edge) begin
            stalled_d = 1'b0;
            cnt_d     = '0;
            state_d   = TRACK;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tick         <= 1'b0;
      rise         <= 1'b0;
      fall         <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
      edge_cnt     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tick         <= tick_d;
      rise         <= rise_d;
      fall         <= fall_d;
      period       <= period_d;
      period_valid <= valid_d;
      stalled      <= stalled_d;
      edge_cnt     <= edge_cnt_d;
    end
  end

endmodule

// File: tb/tb_scl_tick_receiver.sv
// Bench for scl_tick_receiver: two instances (both-edge and rising-only) share
// stimulus; a timestamp-based reference model checks both every cycle, and
// directed vectors/sequences pin down latency, stall timing, en/rst corners and wrap.
module tb_scl_tick_receiver;

  localparam int unsigned TO = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic scl = 1'b0;

  logic        tick0, rise0, fall0, valid0, stalled0;
  logic [31:0] period0;
  logic [15:0] ecnt0;
  logic        tick1, rise1, fall1, valid1, stalled1;
  logic [31:0] period1;
  logic [15:0] ecnt1;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  scl_tick_receiver #(.CNT_W(32), .TIMEOUT(TO), .SYNC_STAGES(2), .EDGE_MODE(0)) dut (
    .clk(clk), .rst(rst), .clk_scl_in(scl), .en(en),
    .tick(tick0), .rise(rise0), .fall(fall0), .period(period0),
    .period_valid(valid0), .stalled(stalled0), .edge_cnt(ecnt0)
  );

  scl_tick_receiver #(.CNT_W(32), .TIMEOUT(TO), .SYNC_STAGES(2), .EDGE_MODE(1)) dut_r (
    .clk(clk), .rst(rst), .clk_scl_in(scl), .en(en),
    .tick(tick1), .rise(rise1), .fall(fall1), .period(period1),
    .period_valid(valid1), .stalled(stalled1), .edge_cnt(ecnt1)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: a receiver is either off, waiting, tracking or stalled;
  // it remembers when the last edge (or enable) happened and derives period
  // and stall purely from elapsed cycle counts.
  typedef struct {
    bit          run, trk, stl;
    int unsigned ref_t;
    logic [31:0] period;
    bit          valid, stalled;
    logic [15:0] ecnt;
    bit          tick, rise, fall;
  } mdl_t;

  function automatic mdl_t mdl_step(mdl_t m, bit en_s, bit qe, bit up, int unsigned t);
    mdl_t n = m;
    n.tick = 1'b0; n.rise = 1'b0; n.fall = 1'b0;
    if (!en_s) begin
      n = '{default: '0};
    end else if (!m.run) begin
      n.run = 1'b1; n.ref_t = t;
    end else if (qe) begin
      n.tick = 1'b1; n.rise = up; n.fall = !up;
      n.ecnt = m.ecnt + 16'd1;
      if (m.trk) begin
        n.period = t - m.ref_t;
        n.valid  = 1'b1;
      end
      n.trk = 1'b1; n.stl = 1'b0; n.stalled = 1'b0; n.ref_t = t;
    end else if (!m.stl && (t - m.ref_t) == TO) begin
      n.stl = 1'b1; n.trk = 1'b0; n.stalled = 1'b1; n.valid = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [63:0] pack_m(mdl_t m);
    return {11'b0, m.tick, m.rise, m.fall, m.valid, m.stalled, m.ecnt, m.period};
  endfunction

  mdl_t        m0, m1;
  bit          h1, h2, h3;      // input as sampled 1, 2 and 3 clocks ago
  int unsigned t_cyc      = 0;
  int unsigned tick_seen  = 0;
  int unsigned rfall_seen = 0;

  // Per-cycle monitor, sampling 1 time unit after each rising clk edge.
  initial begin
    m0 = '{default: '0};
    m1 = '{default: '0};
    forever begin
      @(posedge clk);
      #1;
      t_cyc++;
      if (rst) begin
        m0 = '{default: '0};
        m1 = '{default: '0};
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      end else begin
        m0 = mdl_step(m0, en, h2 != h3, h2, t_cyc);
        m1 = mdl_step(m1, en, h2 && !h3, h2, t_cyc);
        h3 = h2; h2 = h1; h1 = scl;
      end
      if (tick0) tick_seen++;
      if (fall1) rfall_seen++;
      check($sformatf("mon_both@%0d", t_cyc),
            {11'b0, tick0, rise0, fall0, valid0, stalled0, ecnt0, period0}, pack_m(m0));
      check($sformatf("mon_rise@%0d", t_cyc),
            {11'b0, tick1, rise1, fall1, valid1, stalled1, ecnt1, period1}, pack_m(m1));
    end
  end

  typedef struct {
    logic        scl, en, tick, rise, fall;
    logic [31:0] period;
    logic        valid;
    logic [15:0] ecnt;
    logic        rtick;
  } vec_t;

  function automatic vec_t mk(bit s, bit e, bit t, bit r, bit f, int p, bit v, int c, bit rt);
    vec_t x;
    x.scl = s; x.en = e; x.tick = t; x.rise = r; x.fall = f;
    x.period = 32'(p); x.valid = v; x.ecnt = 16'(c); x.rtick = rt;
    return x;
  endfunction

  vec_t vecs [24];

  initial begin
    int unsigned snap;
    int unsigned hold;

    // Toggle every 5 clocks from row 2: ticks 2 rows after each toggle.
    //              scl en tk rs fl per v cnt rtk
    vecs[0]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 1, 1, 1, 0, 0, 0, 1, 1);
    vecs[5]  = mk(1, 1, 0, 0, 0, 0, 0, 1, 0);
    vecs[6]  = mk(1, 1, 0, 0, 0, 0, 0, 1, 0);
    vecs[7]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 0);
    vecs[8]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 0);
    vecs[9]  = mk(0, 1, 1, 0, 1, 5, 1, 2, 0);
    vecs[10] = mk(0, 1, 0, 0, 0, 5, 1, 2, 0);
    vecs[11] = mk(0, 1, 0, 0, 0, 5, 1, 2, 0);
    vecs[12] = mk(1, 1, 0, 0, 0, 5, 1, 2, 0);
    vecs[13] = mk(1, 1, 0, 0, 0, 5, 1, 2, 0);
    vecs[14] = mk(1, 1, 1, 1, 0, 5, 1, 3, 1);
    vecs[15] = mk(1, 1, 0, 0, 0, 5, 1, 3, 0);
    vecs[16] = mk(1, 1, 0, 0, 0, 5, 1, 3, 0);
    vecs[17] = mk(0, 1, 0, 0, 0, 5, 1, 3, 0);
    vecs[18] = mk(0, 1, 0, 0, 0, 5, 1, 3, 0);
    vecs[19] = mk(0, 1, 1, 0, 1, 5, 1, 4, 0);
    vecs[20] = mk(0, 1, 0, 0, 0, 5, 1, 4, 0);
    vecs[21] = mk(0, 1, 0, 0, 0, 5, 1, 4, 0);
    vecs[22] = mk(0, 1, 0, 0, 0, 5, 1, 4, 0);
    vecs[23] = mk(0, 1, 0, 0, 0, 5, 1, 4, 0);

    repeat (3) @(negedge clk);
    check("reset_outputs", {11'b0, tick0, rise0, fall0, valid0, stalled0, ecnt0, period0}, 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Steady 5-cycle toggling, both instances.
    for (int i = 0; i < 24; i++) begin
      scl = vecs[i].scl;
      en  = vecs[i].en;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            64'({tick0, rise0, fall0, valid0, ecnt0, period0}),
            64'({vecs[i].tick, vecs[i].rise, vecs[i].fall, vecs[i].valid, vecs[i].ecnt, vecs[i].period}));
      check($sformatf("vec%0d_rise_only", i), 64'(tick1), 64'(vecs[i].rtick));
    end
    check("rise_only_period", 64'(period1), 64'd10);
    check("rise_only_valid",  64'(valid1),  64'd1);
    check("rise_only_cnt",    64'(ecnt1),   64'd2);

    // Edges stop: stall exactly 20 cycles after the last tick, then recover.
    repeat (15) @(negedge clk);
    check("pre_stall", 64'({stalled0, valid0}), 64'b01);
    @(negedge clk);
    check("stall_flags",  64'({stalled0, valid0}), 64'b10);
    check("stall_period", 64'(period0), 64'd5);
    scl = 1'b1;
    repeat (3) @(negedge clk);
    check("restart_tick", 64'({tick0, rise0, stalled0, valid0}), 64'b1100);
    check("restart_cnt",  64'(ecnt0), 64'd5);
    repeat (2) @(negedge clk);
    scl = 1'b0;
    repeat (3) @(negedge clk);
    check("second_tick",   64'({tick0, fall0, valid0}), 64'b111);
    check("second_period", 64'(period0), 64'd5);
    check("second_cnt",    64'(ecnt0), 64'd6);

    // Input held high across reset release and en 0->1: no spurious edge.
    rst = 1'b1; en = 1'b0; scl = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    snap = tick_seen;
    en = 1'b1;
    repeat (10) @(negedge clk);
    check("held_high_ticks", 64'(tick_seen - snap), 64'd0);
    check("held_high_cnt",   64'({ecnt0, ecnt1}), 64'd0);
    check("held_high_stall", 64'(stalled0), 64'd0);
    scl = 1'b0;
    repeat (5) @(negedge clk);
    scl = 1'b1;
    repeat (5) @(negedge clk);
    check("track_before_rst", 64'({valid0, period0}), {31'b0, 1'b1, 32'd5});
    rst = 1'b1;
    #1;
    check("async_rst_both",  {11'b0, tick0, rise0, fall0, valid0, stalled0, ecnt0, period0}, 64'd0);
    check("async_rst_rise",  {11'b0, tick1, rise1, fall1, valid1, stalled1, ecnt1, period1}, 64'd0);
    en = 1'b0; scl = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // en falls in the same cycle an edge reaches the detector.
    en = 1'b1;
    repeat (2) @(negedge clk);
    scl = 1'b1;
    repeat (5) @(negedge clk);
    scl = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_drop_valid", 64'(valid0), 64'd1);
    scl = 1'b1;
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("drop_no_tick", 64'({tick0, tick1}), 64'd0);
    check("drop_cleared", 64'({valid0, ecnt0, period0}), 64'd0);
    @(negedge clk);
    check("drop_late_tick", 64'({tick0, tick1}), 64'd0);

    // 65536 edges, one per clock: edge_cnt wraps, no pulse lost.
    en = 1'b1;
    repeat (3) @(negedge clk);
    snap = tick_seen;
    for (int i = 0; i < 65536; i++) begin
      scl = ~scl;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("wrap_ticks",        64'(tick_seen - snap), 64'd65536);
    check("wrap_cnt",          64'(ecnt0), 64'd0);
    check("wrap_period",       64'({valid0, period0}), {31'b0, 1'b1, 32'd1});
    check("wrap_rise_cnt",     64'(ecnt1), 64'd32768);
    check("wrap_rise_period",  64'(period1), 64'd2);

    // Randomized stretch: variable hold lengths, en drops, occasional resets.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) en = ~en;
      if (hold == 0) begin
        scl  = ~scl;
        hold = $urandom_range(1, 30);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    check("rise_only_never_fall", 64'(rfall_seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
